// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - MEM/WB write-back: result select, register/flags commit, bypassed reads, commit counter
module writeback_regfile #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16,
    parameter int CNTW  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     RegWriteW,
    input  logic                     MemtoRegW,
    input  logic                     FlagsWriteW,
    input  logic [1:0]               ALUFlagsW,
    input  logic [$clog2(NREGS)-1:0] WA3W,
    input  logic [WIDTH-1:0]         ReadDataW,
    input  logic [WIDTH-1:0]         ALUOutW,
    input  logic [$clog2(NREGS)-1:0] RA1D,
    input  logic [$clog2(NREGS)-1:0] RA2D,
    input  logic [$clog2(NREGS)-1:0] RA3D,
    output logic [WIDTH-1:0]         ResultW,
    output logic [WIDTH-1:0]         RD1D,
    output logic [WIDTH-1:0]         RD2D,
    output logic [WIDTH-1:0]         RD3D,
    output logic [1:0]               FlagsD,
    output logic [CNTW-1:0]          CommitCount
);

    localparam int AW = $clog2(NREGS);

    logic [WIDTH-1:0] regs [NREGS];
    logic [1:0]       flags;
    logic [CNTW-1:0]  commit_count;
    logic             active;
    logic             commit;

    assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;
    assign commit  = RegWriteW || FlagsWriteW;

    // active stays low through the edge on which reset is released, so a
    // commit coinciding with the release edge is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active       <= 1'b0;
            flags        <= 2'b00;
            commit_count <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            active <= 1'b1;
            if (active) begin
                if (RegWriteW) begin
                    regs[WA3W] <= ResultW;
                end
                if (FlagsWriteW) begin
                    flags <= ALUFlagsW;
                end
                if (commit && (commit_count != {CNTW{1'b1}})) begin
                    commit_count <= commit_count + CNTW'(1);
                end
            end
        end
    end

    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] ra);
        return (RegWriteW && (WA3W == ra)) ? ResultW : regs[ra];
    endfunction

    always_comb begin
        RD1D = read_port(RA1D);
        RD2D = read_port(RA2D);
        RD3D = read_port(RA3D);
    end

    assign FlagsD      = FlagsWriteW ? ALUFlagsW : flags;
    assign CommitCount = commit_count;

endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - randomized and directed bench for writeback_regfile against a behavioural model
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        RegWriteW = 1'b0, MemtoRegW = 1'b0, FlagsWriteW = 1'b0;
    logic [1:0]  ALUFlagsW = 2'b00;
    logic [3:0]  WA3W = 4'd0, RA1D = 4'd0, RA2D = 4'd0, RA3D = 4'd0;
    logic [31:0] ReadDataW = 32'd0, ALUOutW = 32'd0;

    logic [31:0] ResultW, RD1D, RD2D, RD3D;
    logic [1:0]  FlagsD;
    logic [15:0] CommitCount;

    logic [31:0] s_ResultW, s_RD1D, s_RD2D, s_RD3D;
    logic [1:0]  s_FlagsD;
    logic [3:0]  s_CommitCount;

    int checks = 0;
    int errors = 0;

    writeback_regfile dut (
        .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .FlagsWriteW(FlagsWriteW), .ALUFlagsW(ALUFlagsW), .WA3W(WA3W),
        .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .RA1D(RA1D), .RA2D(RA2D), .RA3D(RA3D),
        .ResultW(ResultW), .RD1D(RD1D), .RD2D(RD2D), .RD3D(RD3D),
        .FlagsD(FlagsD), .CommitCount(CommitCount)
    );

    writeback_regfile #(.CNTW(4)) dut_sat (
        .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .FlagsWriteW(FlagsWriteW), .ALUFlagsW(ALUFlagsW), .WA3W(WA3W),
        .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .RA1D(RA1D), .RA2D(RA2D), .RA3D(RA3D),
        .ResultW(s_ResultW), .RD1D(s_RD1D), .RD2D(s_RD2D), .RD3D(s_RD3D),
        .FlagsD(s_FlagsD), .CommitCount(s_CommitCount)
    );

    always #5 clk = ~clk;

    // Behavioural model: architectural state plus an unbounded commit tally.
    logic [31:0] m_regs [16];
    logic [1:0]  m_flags = 2'b00;
    int          m_commits = 0;
    logic        rst_q = 1'b0;

    initial begin
        for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge reset) begin
        for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
        m_flags   = 2'b00;
        m_commits = 0;
    end

    // A commit lands only if reset was already high throughout the preceding cycle.
    always @(posedge clk) begin
        if (rst_q && reset) begin
            if (RegWriteW) m_regs[WA3W] = MemtoRegW ? ReadDataW : ALUOutW;
            if (FlagsWriteW) m_flags = ALUFlagsW;
            if (RegWriteW || FlagsWriteW) m_commits++;
        end
    end

    always @(negedge clk) begin
        logic [31:0] res;
        #2;
        rst_q = reset;
        res = MemtoRegW ? ReadDataW : ALUOutW;
        chk("result", 64'(ResultW), 64'(res));
        chk("rd1", 64'(RD1D), 64'((RegWriteW && WA3W == RA1D) ? res : m_regs[RA1D]));
        chk("rd2", 64'(RD2D), 64'((RegWriteW && WA3W == RA2D) ? res : m_regs[RA2D]));
        chk("rd3", 64'(RD3D), 64'((RegWriteW && WA3W == RA3D) ? res : m_regs[RA3D]));
        chk("flags", 64'(FlagsD), 64'(FlagsWriteW ? ALUFlagsW : m_flags));
        chk("count16", 64'(CommitCount), 64'((m_commits > 65535) ? 65535 : m_commits));
        chk("count4", 64'(s_CommitCount), 64'((m_commits > 15) ? 15 : m_commits));
        chk("sat_rd1", 64'(s_RD1D), 64'(RD1D));
    end

    task automatic bubble();
        RegWriteW   = 1'b0;
        FlagsWriteW = 1'b0;
        MemtoRegW   = 1'($urandom);
        ALUFlagsW   = 2'($urandom);
        WA3W        = 4'($urandom);
        ReadDataW   = $urandom;
        ALUOutW     = $urandom;
    endtask

    task automatic drive_rand();
        RegWriteW   = ($urandom_range(0, 2) != 0);
        FlagsWriteW = ($urandom_range(0, 3) == 0);
        MemtoRegW   = 1'($urandom);
        ALUFlagsW   = 2'($urandom);
        WA3W        = 4'($urandom);
        ReadDataW   = $urandom;
        ALUOutW     = $urandom;
        RA1D        = 4'($urandom);
        RA2D        = ($urandom_range(0, 3) == 0) ? WA3W : 4'($urandom);
        RA3D        = ($urandom_range(0, 3) == 0) ? RA1D : 4'($urandom);
    endtask

    task automatic alu_write(input logic [3:0] wa, input logic [31:0] val);
        RegWriteW = 1'b1; MemtoRegW = 1'b0; FlagsWriteW = 1'b0;
        WA3W = wa; ALUOutW = val; ReadDataW = $urandom;
    endtask

    initial begin
        // Commit pending on the release edge must be dropped.
        @(negedge clk); bubble();
        @(negedge clk);
        alu_write(4'd1, 32'h55); FlagsWriteW = 1'b1; ALUFlagsW = 2'b11;
        @(posedge clk); reset = 1'b1;
        @(negedge clk); bubble(); RA1D = 4'd1; #3;
        chk("rel_rd1", 64'(RD1D), 64'h0);
        chk("rel_flags", 64'(FlagsD), 64'h0);
        chk("rel_cnt", 64'(CommitCount), 64'h0);

        // Test 1: reset mid-run clears state immediately.
        @(negedge clk); alu_write(4'd3, 32'h1234); FlagsWriteW = 1'b1; ALUFlagsW = 2'b11;
        @(negedge clk); bubble(); RA1D = 4'd3; #3;
        chk("t1_pre_rd1", 64'(RD1D), 64'h1234);
        @(negedge clk); bubble(); reset = 1'b0; #3;
        chk("t1_rd1", 64'(RD1D), 64'h0);
        chk("t1_flags", 64'(FlagsD), 64'h0);
        chk("t1_cnt", 64'(CommitCount), 64'h0);
        @(posedge clk); reset = 1'b1;

        // Test 2: ALU write visible next cycle.
        @(negedge clk); alu_write(4'd5, 32'hDEADBEEF);
        @(negedge clk); bubble(); RA2D = 4'd5; #3;
        chk("t2_rd2", 64'(RD2D), 64'hDEADBEEF);
        chk("t2_cnt", 64'(CommitCount), 64'd1);

        // Test 3: load with bypass on all three ports.
        @(negedge clk);
        RegWriteW = 1'b1; MemtoRegW = 1'b1; WA3W = 4'd7; ReadDataW = 32'hCAFE0001;
        ALUOutW = 32'h0BAD0BAD; RA1D = 4'd7; RA2D = 4'd7; RA3D = 4'd7; #3;
        chk("t3_rd1", 64'(RD1D), 64'hCAFE0001);
        chk("t3_rd2", 64'(RD2D), 64'hCAFE0001);
        chk("t3_rd3", 64'(RD3D), 64'hCAFE0001);
        @(negedge clk); bubble(); #3;
        chk("t3_held", 64'(RD1D), 64'hCAFE0001);
        chk("t3_cnt", 64'(CommitCount), 64'd2);

        // Test 4: flags-only commit.
        @(negedge clk); bubble(); FlagsWriteW = 1'b1; ALUFlagsW = 2'b10; RA2D = 4'd5; #3;
        chk("t4_flags_byp", 64'(FlagsD), 64'h2);
        @(negedge clk); bubble(); #3;
        chk("t4_flags", 64'(FlagsD), 64'h2);
        chk("t4_rd2", 64'(RD2D), 64'hDEADBEEF);
        chk("t4_cnt", 64'(CommitCount), 64'd3);

        // Test 5: combined commit counts once, then bubbles change nothing.
        @(negedge clk); alu_write(4'd15, 32'd9); FlagsWriteW = 1'b1; ALUFlagsW = 2'b01;
        RA3D = 4'd15;
        repeat (3) begin @(negedge clk); bubble(); end
        #3;
        chk("t5_rd3", 64'(RD3D), 64'd9);
        chk("t5_flags", 64'(FlagsD), 64'h1);
        chk("t5_cnt", 64'(CommitCount), 64'd4);

        // Test 6: saturation of the 4-bit counter; register file still written.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); alu_write(4'(i), $urandom);
        end
        @(negedge clk); bubble(); #3;
        chk("t6_sat", 64'(s_CommitCount), 64'd15);
        chk("t6_cnt16", 64'(CommitCount), 64'd24);
        @(negedge clk); alu_write(4'd2, 32'hA5A5);
        @(negedge clk); bubble(); RA1D = 4'd2; #3;
        chk("t6_rd1", 64'(s_RD1D), 64'hA5A5);
        chk("t6_sat_hold", 64'(s_CommitCount), 64'd15);

        // Random phase with periodic resets released on a clock edge.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); drive_rand();
            if (i % 400 == 399) begin
                reset = 1'b0;
                @(negedge clk); drive_rand();
                @(posedge clk); reset = 1'b1;
            end
        end

        @(negedge clk); bubble(); #4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
